// File: rtl/ysyx22041405_lsu_pkg.sv
// ysyx22041405_lsu_pkg: shared size encodings, FSM states and access-legality helper for the LSU.
package ysyx22041405_lsu_pkg;
   localparam int LANES = 4;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;
   function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'b11) || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
   endfunction
endpackage

// File: rtl/ysyx22041405_lsu_align.sv
// ysyx22041405_lsu_align: store lane replication/strobes and load extract/extend.
module ysyx22041405_lsu_align
   import ysyx22041405_lsu_pkg::*;
(
   input  logic [1:0]       off,
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   input  logic [31:0]      st_data,
   input  logic [31:0]      ld_word,
   output logic [31:0]      lane_data,
   output logic [LANES-1:0] lane_strb,
   output logic [31:0]      ld_data
);
   logic [31:0] shifted;
   logic        sext_b, sext_h;
   assign shifted   = ld_word >> {off, 3'b000};
   assign sext_b    = ~is_unsigned & shifted[7];
   assign sext_h    = ~is_unsigned & shifted[15];
   assign lane_data = size == SZ_B ? {4{st_data[7:0]}} : size == SZ_H ? {2{st_data[15:0]}} : st_data;
   assign lane_strb = size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : 4'hF;
   assign ld_data   = size == SZ_B ? {{24{sext_b}}, shifted[7:0]} :
                      size == SZ_H ? {{16{sext_h}}, shifted[15:0]} : shifted;
endmodule

// File: rtl/ysyx22041405_lsu.sv
// ysyx22041405_lsu: load/store unit owning the data bus; one access in flight,
// one resp_valid pulse per accepted request.
module ysyx22041405_lsu
   import ysyx22041405_lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [WIDTH-1:0]   req_addr,
   input  logic [WIDTH-1:0]   req_wdata,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   output logic               resp_valid,
   output logic [WIDTH-1:0]   resp_rdata,
   output logic               resp_err,
   output logic               bus_valid,
   input  logic               bus_ready,
   output logic               bus_we,
   output logic [WIDTH-1:0]   bus_addr,
   output logic [WIDTH-1:0]   bus_wdata,
   output logic [WIDTH/8-1:0] bus_wstrb,
   input  logic               bus_rvalid,
   input  logic [WIDTH-1:0]   bus_rdata
);
   state_t             state, state_nxt;
   logic               we_q, uns_q, err_q;
   logic [1:0]         size_q;
   logic [WIDTH-1:0]   addr_q, wdata_q, rdata_q, lane_data, ld_data;
   logic [WIDTH/8-1:0] lane_strb;

   ysyx22041405_lsu_align u_align (
      .off         (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .st_data     (wdata_q),
      .ld_word     (bus_rdata),
      .lane_data   (lane_data),
      .lane_strb   (lane_strb),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = bad_access(req_size, req_addr[1:0]) ? S_RESP : S_REQ;
         S_REQ:   if (bus_ready) state_nxt = we_q ? S_RESP : S_WAIT;
         S_WAIT:  if (bus_rvalid) state_nxt = S_RESP;
         default: state_nxt = S_IDLE;
      endcase
   end

   // bus outputs decode straight from state so an async reset drops them immediately
   assign req_ready  = state == S_IDLE;
   assign bus_valid  = state == S_REQ;
   assign bus_we     = bus_valid & we_q;
   assign bus_addr   = {addr_q[WIDTH-1:2], 2'b00};
   assign bus_wdata  = lane_data;
   assign bus_wstrb  = bus_we ? lane_strb : '0;
   assign resp_valid = state == S_RESP;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= bad_access(req_size, req_addr[1:0]);
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
         end
         if (state == S_WAIT && bus_rvalid) rdata_q <= ld_data;
      end
   end
endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// tb_ysyx22041405_lsu: scoreboard bench with a memory-function bus model and randomized accesses.
module tb_ysyx22041405_lsu;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        resp_valid, resp_err, bus_valid, bus_ready, bus_we, bus_rvalid;
   logic [31:0] resp_rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   ysyx22041405_lsu dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] rdata; bit err; int t0; int lat; bit exact;} resp_t;
   typedef struct {logic [31:0] addr; bit we; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;
   resp_t rq[$];
   bus_t  bq[$];
   int total = 0, bad = 0, cyc = 0;
   bit fixed = 1'b0;
   int rdy_wait = 0, rv_wait = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // memory is a pure function of the word address; stores do not alter it
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      logic [31:0] w;
      w = a - (a % 4);
      if (w == 32'h80000000) return 32'h12F45678;
      return (w * 32'h9E3779B1) ^ 32'h5EED1234;
   endfunction

   function automatic bit illegal(input logic [31:0] a, input int sz);
      return sz == 3 || (a % (1 << sz)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int sz, input bit u);
      longint unsigned v, m;
      m = 64'd1 << (8 << sz);
      v = (w >> (8 * off)) % m;
      if (!u && v >= m / 2) v = v - m;
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int sz);
      return sz == 0 ? (d % 256) * 32'h01010101 : sz == 1 ? (d % 65536) * 32'h00010001 : d;
   endfunction

   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input int sz, input bit u);
      resp_t r;
      bus_t  b;
      int    off, waited;
      bit    e;
      waited = 0;
      @(negedge clk);
      while (!req_ready) begin
         if (++waited > 200) begin
            $display("FAIL req_ready_timeout: got 0 want 1");
            $fatal(1, "req_ready never returned");
         end
         @(negedge clk);
      end
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      req_size = sz[1:0]; req_unsigned = u;
      off = a % 4;
      e = illegal(a, sz);
      r.t0 = cyc;
      r.err = e;
      r.rdata = (e || we) ? 32'h0 : ref_load(mem_f(a), off, sz, u);
      r.exact = e || fixed;
      r.lat = e ? 1 : we ? 2 + (fixed ? rdy_wait : 0) : 3 + (fixed ? rdy_wait + rv_wait : 0);
      b.addr = a - off; b.we = we; b.wdata = ref_wdata(d, sz);
      b.wstrb = we ? 4'(((1 << (1 << sz)) - 1) << off) : 4'h0;
      @(posedge clk);
      rq.push_back(r);
      if (!e) bq.push_back(b);
      #1;
      req_valid = e ? 1'b0 : 1'($urandom_range(0, 1));
      req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom); req_unsigned = 1'($urandom);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // bus model: handshake scoreboard, hold checks, load data return
   initial begin
      bit pend = 0, pv = 0, phs = 0, hs;
      int dly = 0, vcnt = 0;
      logic [31:0] paddr = '0, p_addr = '0, p_wdata = '0;
      logic [5:0]  p_ctl = '0;
      bus_t b;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst && pv && !phs) begin
            chk("hold_addr", bus_addr, p_addr);
            chk("hold_ctl", {26'h0, bus_valid, bus_we, bus_wstrb}, {26'h0, p_ctl});
            if (bus_we) chk("hold_wdata", bus_wdata, p_wdata);
         end
         bus_ready = fixed ? (!bus_valid || vcnt >= rdy_wait) : ($urandom_range(0, 3) != 0);
         if (pend) begin
            bus_rvalid = dly == 0;
            bus_rdata = dly == 0 ? mem_f(paddr) : $urandom;
            if (dly > 0) dly--;
         end else begin
            bus_rvalid = !fixed && $urandom_range(0, 3) == 0;
            bus_rdata = $urandom;
         end
         if (pend && bus_rvalid) pend = 0;
         hs = bus_valid && bus_ready;
         if (hs) begin
            if (bq.size() == 0) begin
               total++; bad++;
               $display("FAIL bus_unexpected: got addr %h want no request", bus_addr);
            end else begin
               b = bq.pop_front();
               chk("bus_addr", bus_addr, b.addr);
               chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
               chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, b.wstrb});
               if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
            end
            if (!bus_we) begin
               pend = 1; paddr = bus_addr;
               dly = fixed ? rv_wait : $urandom_range(0, 3);
            end
         end
         vcnt = (bus_valid && !hs) ? vcnt + 1 : 0;
         pv = bus_valid; phs = hs;
         p_addr = bus_addr; p_wdata = bus_wdata; p_ctl = {1'b1, bus_we, bus_wstrb};
      end
   end

   // response monitor
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         chk("req_ready", {31'h0, req_ready}, {31'h0, rq.size() == 0});
         if (resp_valid) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL resp_spurious: got resp_valid 1 want 0 (t=%0t)", $time);
            end else begin
               r = rq.pop_front();
               chk("resp_rdata", resp_rdata, r.rdata);
               chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
               if (r.exact) chk("latency", cyc - r.t0, r.lat);
               else chk("latency_min", {31'h0, (cyc - r.t0) >= r.lat}, 32'h1);
            end
         end
      end
   end

   initial begin
      int n;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_bus", {bus_valid, bus_we, bus_wstrb, resp_valid, resp_err}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      @(posedge clk); #2 rst = 1'b1;
      fixed = 1'b1; rdy_wait = 0; rv_wait = 0;
      issue(1, 32'h80000004, 32'hDEADBEEF, 2, 0);
      issue(1, 32'h80000003, 32'h000000A5, 0, 0);
      issue(0, 32'h80000002, 32'h0, 0, 0);
      issue(0, 32'h80000002, 32'h0, 0, 1);
      issue(0, 32'h80000002, 32'h0, 1, 1);
      issue(0, 32'h80000002, 32'h0, 1, 0);
      issue(0, 32'h80000001, 32'h0, 1, 0);
      issue(1, 32'h80000006, 32'h0000BEEF, 3, 0);
      rdy_wait = 3; rv_wait = 2;
      issue(1, 32'h80000012, 32'h1234CAFE, 1, 0);
      issue(0, 32'h80000003, 32'h0, 0, 0);
      issue(0, 32'h80000008, 32'h0, 2, 0);
      // abort a load in WAIT; its late rvalid must not produce a response
      rdy_wait = 0; rv_wait = 4;
      issue(0, 32'h80000000, 32'h0, 2, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      rq.delete();
      #1;
      chk("abort_bus_valid", {31'h0, bus_valid}, 32'h0);
      chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #2 rst = 1'b1;
      repeat (8) @(negedge clk);
      fixed = 1'b0;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a - (a % 4) + 32'($urandom_range(0, 1) * 2);
         issue(1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom));
      end
      n = 0;
      while (rq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("drain_resp", rq.size(), 32'h0);
      chk("drain_bus", bq.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
